// File: rtl/occupancy_counter_pkg.sv
// Shared types and constants for the doorway occupancy counter: FSM state
// encoding, passage events and BCD digit helpers.
package occupancy_counter_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_NINE = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E1,
    ST_E2,
    ST_E3,
    ST_X1,
    ST_X2,
    ST_X3
  } fsm_state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_ENTER,
    EV_EXIT
  } pass_event_t;

  // Split a binary ceiling into BCD digits so that saturation checks stay digit-wise.
  function automatic bcd_t tens_of(input int unsigned value);
    return bcd_t'(value / 10);
  endfunction

  function automatic bcd_t ones_of(input int unsigned value);
    return bcd_t'(value % 10);
  endfunction

endpackage

// File: rtl/occupancy_counter_if.sv
// Beam, clear and occupancy-display signals shared between the counter and
// whatever drives or consumes them.
interface occupancy_counter_if;
  import occupancy_counter_pkg::*;

  logic OuterBeam;
  logic InnerBeam;
  logic Clear;
  bcd_t PersonTens;
  bcd_t PersonOnes;
  logic Full;
  logic Empty;
  logic Rejected;

  modport master (
    output OuterBeam, InnerBeam, Clear,
    input  PersonTens, PersonOnes, Full, Empty, Rejected
  );

  modport slave (
    input  OuterBeam, InnerBeam, Clear,
    output PersonTens, PersonOnes, Full, Empty, Rejected
  );

endinterface

// File: rtl/occupancy_counter_beam_debouncer.sv
// Two-flop synchroniser followed by a debouncer: the output follows the
// synchronised beam only after it has differed for DEBOUNCE_CYCLES cycles in a row.
module beam_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic beam_raw,
  output logic beam_db
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q, sync_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sync_d = {sync_q[0], beam_raw};
    db_d   = db_q;
    cnt_d  = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d = sync_q[1];
      else                                      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign beam_db = db_q;

endmodule

// File: rtl/occupancy_counter.sv
// Doorway occupancy counter: debounced beams feed a direction FSM whose
// ENTER/EXIT events drive a saturating two-digit BCD up/down counter.
module occupancy_counter
  import occupancy_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 100000000,
  parameter int unsigned MAX_PERSONS     = 44
) (
  input  logic               Clock,
  input  logic               Reset,
  occupancy_counter_if.slave bus
);

  localparam bcd_t        MAX_TENS = tens_of(MAX_PERSONS);
  localparam bcd_t        MAX_ONES = ones_of(MAX_PERSONS);
  localparam int unsigned TMR_W    = $clog2(TIMEOUT_CYCLES + 1);

  logic outer_db, inner_db;

  beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_outer (
    .clk      (Clock),
    .rst      (Reset),
    .beam_raw (bus.OuterBeam),
    .beam_db  (outer_db)
  );

  beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inner (
    .clk      (Clock),
    .rst      (Reset),
    .beam_raw (bus.InnerBeam),
    .beam_db  (inner_db)
  );

  fsm_state_t       state_q, state_d;
  pass_event_t      event_q, event_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    event_d = EV_NONE;
    case (state_q)
      ST_IDLE: begin
        // Both beams broken from idle cannot be attributed to a direction.
        if (outer_db && !inner_db)      state_d = ST_E1;
        else if (!outer_db && inner_db) state_d = ST_X1;
      end
      ST_E1: begin
        if (outer_db && inner_db)        state_d = ST_E2;
        else if (!outer_db && !inner_db) state_d = ST_IDLE;
      end
      ST_E2: begin
        if (!outer_db && inner_db)      state_d = ST_E3;
        else if (outer_db && !inner_db) state_d = ST_E1;
      end
      ST_E3: begin
        if (!outer_db && !inner_db) begin
          state_d = ST_IDLE;
          event_d = EV_ENTER;
        end else if (outer_db && inner_db) begin
          state_d = ST_E2;
        end
      end
      ST_X1: begin
        if (outer_db && inner_db)        state_d = ST_X2;
        else if (!outer_db && !inner_db) state_d = ST_IDLE;
      end
      ST_X2: begin
        if (outer_db && !inner_db)      state_d = ST_X3;
        else if (!outer_db && inner_db) state_d = ST_X1;
      end
      ST_X3: begin
        if (!outer_db && !inner_db) begin
          state_d = ST_IDLE;
          event_d = EV_EXIT;
        end else if (outer_db && inner_db) begin
          state_d = ST_X2;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled passage is abandoned without touching the count.
    if (state_q != ST_IDLE && timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      event_d = EV_NONE;
    end

    timer_d = (state_q == ST_IDLE || state_d != state_q) ? '0 : timer_q + 1'b1;
  end

  bcd_t tens_q, tens_d, ones_q, ones_d;
  logic full_q, full_d, empty_q, empty_d, rejected_q, rejected_d;

  always_comb begin
    tens_d     = tens_q;
    ones_d     = ones_q;
    rejected_d = 1'b0;
    // Clear discards any event arriving in the same cycle.
    if (bus.Clear) begin
      tens_d = '0;
      ones_d = '0;
    end else begin
      case (event_q)
        EV_ENTER: begin
          if (full_q) begin
            rejected_d = 1'b1;
          end else if (ones_q == BCD_NINE) begin
            ones_d = '0;
            tens_d = tens_q + 1'b1;
          end else begin
            ones_d = ones_q + 1'b1;
          end
        end
        EV_EXIT: begin
          if (empty_q) begin
            rejected_d = 1'b1;
          end else if (ones_q == '0) begin
            ones_d = BCD_NINE;
            tens_d = tens_q - 1'b1;
          end else begin
            ones_d = ones_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    full_d  = (tens_d == MAX_TENS) && (ones_d == MAX_ONES);
    empty_d = (tens_d == '0) && (ones_d == '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      event_q    <= EV_NONE;
      timer_q    <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      event_q    <= event_d;
      timer_q    <= timer_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rejected_q <= rejected_d;
    end
  end

  assign bus.PersonTens = tens_q;
  assign bus.PersonOnes = ones_q;
  assign bus.Full       = full_q;
  assign bus.Empty      = empty_q;
  assign bus.Rejected   = rejected_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Scoreboard bench: stimulus tasks push the expected display after each
// passage; a monitor pops and compares whenever the DUT outputs change.
module tb_occupancy_counter;
  import occupancy_counter_pkg::*;

  localparam int DEB  = 4;
  localparam int TMO  = 100;
  localparam int MAXP = 44;
  localparam int TAIL = 12;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       full;
    logic       empty;
    logic       rej;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  occupancy_counter_if bus_if ();

  occupancy_counter #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO),
    .MAX_PERSONS     (MAXP)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_if)
  );

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_count = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (tens,ones,full,empty,rej packed)", name, act, exp);
  endtask

  function automatic obs_t model_obs(input int cnt, input bit rej);
    obs_t o;
    o.tens  = 4'(cnt / 10);
    o.ones  = 4'(cnt % 10);
    o.full  = (cnt == MAXP);
    o.empty = (cnt == 0);
    o.rej   = rej;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.tens  = bus_if.PersonTens;
    o.ones  = bus_if.PersonOnes;
    o.full  = bus_if.Full;
    o.empty = bus_if.Empty;
    o.rej   = bus_if.Rejected;
    return o;
  endfunction

  // Reference model: occupancy as a plain integer with saturation at both ends.
  task automatic model_step(input bit enter);
    bit blocked = enter ? (model_count == MAXP) : (model_count == 0);
    if (blocked) begin
      exp_q.push_back(model_obs(model_count, 1'b1));
      exp_q.push_back(model_obs(model_count, 1'b0));
    end else begin
      model_count += enter ? 1 : -1;
      exp_q.push_back(model_obs(model_count, 1'b0));
    end
  endtask

  task automatic model_clear();
    if (model_count != 0) begin
      model_count = 0;
      exp_q.push_back(model_obs(0, 1'b0));
    end
  endtask

  task automatic set_beams(input bit o, input bit i, input int cycles);
    bus_if.OuterBeam = o;
    bus_if.InnerBeam = i;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic int hold();
    return int'($urandom_range(8, 14));
  endfunction

  task automatic do_entry();
    model_step(1'b1);
    set_beams(1, 0, hold());
    set_beams(1, 1, hold());
    set_beams(0, 1, hold());
    set_beams(0, 0, TAIL);
  endtask

  task automatic do_exit();
    model_step(1'b0);
    set_beams(0, 1, hold());
    set_beams(1, 1, hold());
    set_beams(1, 0, hold());
    set_beams(0, 0, TAIL);
  endtask

  task automatic do_wiggle_entry();
    model_step(1'b1);
    set_beams(1, 0, hold());
    set_beams(1, 1, hold());
    set_beams(1, 0, hold());
    set_beams(1, 1, hold());
    set_beams(0, 1, hold());
    set_beams(0, 0, TAIL);
  endtask

  task automatic do_backout(input bit outer);
    set_beams(outer, !outer, hold());
    set_beams(0, 0, TAIL);
  endtask

  task automatic do_glitch(input bit outer, input int len);
    set_beams(outer, !outer, len);
    set_beams(0, 0, TAIL);
  endtask

  task automatic do_clear();
    model_clear();
    bus_if.Clear = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.Clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Clear held across the whole final phase, covering the cycle the ENTER lands.
  task automatic clear_race_entry();
    model_clear();
    set_beams(1, 0, hold());
    set_beams(1, 1, hold());
    set_beams(0, 1, hold());
    bus_if.Clear = 1'b1;
    set_beams(0, 0, TAIL);
    bus_if.Clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Clear mid-passage wipes the count but leaves the passage in progress.
  task automatic clear_mid_entry();
    model_clear();
    model_step(1'b1);
    set_beams(1, 0, hold());
    bus_if.OuterBeam = 1'b1;
    bus_if.InnerBeam = 1'b1;
    bus_if.Clear = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.Clear = 1'b0;
    repeat (8) @(negedge clk);
    set_beams(0, 1, hold());
    set_beams(0, 0, TAIL);
  endtask

  initial begin : monitor
    obs_t prev, cur;
    wait (mon_en);
    prev = sample();
    forever begin
      @(negedge clk);
      cur = sample();
      if (cur !== prev) begin
        if (exp_q.size() == 0) check("unexpected_change", 32'(cur), 32'(prev));
        else                   check("scoreboard", 32'(cur), 32'(exp_q.pop_front()));
      end
      prev = cur;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1;
    bus_if.OuterBeam = 1'b0;
    bus_if.InnerBeam = 1'b0;
    bus_if.Clear     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(sample()), 32'(model_obs(0, 1'b0)));
    mon_en = 1'b1;
    @(negedge clk);

    do_entry();
    do_exit();
    do_exit();

    repeat (9) do_entry();
    do_entry();
    do_exit();

    while (model_count < MAXP) do_entry();
    do_entry();
    check("full_flag", 32'(bus_if.Full), 32'(1));

    for (int g = 1; g <= 3; g++) do_glitch(1'b1, g);
    do_exit();

    set_beams(1, 0, hold());
    set_beams(1, 1, 150);
    set_beams(0, 1, hold());
    set_beams(0, 0, TAIL);

    do_backout(1'b1);
    do_backout(1'b0);

    do_clear();
    repeat (5) do_entry();
    clear_race_entry();
    check("clear_race_count", 32'(sample()), 32'(model_obs(0, 1'b0)));

    do_entry();
    do_entry();
    clear_mid_entry();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    do_entry();
        2, 3:    do_exit();
        4:       do_backout(1'($urandom_range(0, 1)));
        5:       do_glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        6:       do_clear();
        default: do_wiggle_entry();
      endcase
    end

    if (model_count == 0) do_entry();
    set_beams(1, 0, hold());
    set_beams(1, 1, hold());
    model_count = 0;
    exp_q.push_back(model_obs(0, 1'b0));
    rst = 1'b1;
    set_beams(0, 0, 3);
    rst = 1'b0;
    repeat (TAIL) @(negedge clk);
    check("reset_mid_e2", 32'(sample()), 32'(model_obs(0, 1'b0)));

    do_entry();
    repeat (30) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
Tracks room occupancy from a pair of doorway light-beam sensors and presents the head-count as two BCD digits (PersonTens, PersonOnes) to the downstream temperature-selection stage. Raw beam inputs are synchronised and debounced. A direction FSM then classifies each complete passage as an entry or an exit, and a saturating BCD up/down counter is updated accordingly.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a beam level is accepted (10 ms @ 50 MHz)
TIMEOUT_CYCLES, 100000000, max cycles the FSM may remain outside IDLE before abandoning a passage (2 s @ 50 MHz)
MAX_PERSONS, 44, saturation ceiling of the count; must be 1..99

Ports:
Clock  in  1  system clock; all logic rising-edge
Reset  in  1  synchronous, active-high reset
OuterBeam  in  1  raw outer beam, 1 = broken; asynchronous
InnerBeam  in  1  raw inner beam, 1 = broken; asynchronous
Clear  in  1  synchronous count clear, level-sensitive
PersonTens  out  4  BCD tens digit of occupancy
PersonOnes  out  4  BCD ones digit of occupancy
Full  out  1  count == MAX_PERSONS
Empty  out  1  count == 0
Rejected  out  1  one-cycle pulse: entry at Full, or exit at Empty

Behaviour:
- Reset values: PersonTens=0, PersonOnes=0, Full=0, Empty=1, Rejected=0. FSM=IDLE, sync/debounced beams=0, timers=0.
- Reset applies from any state. It aborts any partial passage, and no count change occurs.
- Input path (per beam): 2-FF synchroniser, then debounce.
  - Debounced value D changes only after the synchronised value differs from D for DEBOUNCE_CYCLES consecutive cycles.
  - Any matching cycle restarts the debounce counter.
- FSM state transitions, evaluated on debounced values (O = outer, I = inner):
  - IDLE: O&~I -> E1; ~O&I -> X1; O&I -> stay IDLE (ambiguous, ignored); ~O&~I -> stay.
  - E1 (outer only): O&I -> E2; ~O&~I -> IDLE (backed out).
  - E2 (both): ~O&I -> E3; O&~I -> E1.
  - E3 (inner only): ~O&~I -> IDLE and issue ENTER; O&I -> E2.
  - X1/X2/X3 mirror E1/E2/E3 with roles of O and I swapped; X3 -> IDLE issues EXIT.
  - Any combination not listed holds the current state.
- Timeout: the timer counts while FSM != IDLE and clears on each state change. At TIMEOUT_CYCLES the FSM returns to IDLE with no count change.
- Count update occurs one cycle after the FSM transition that issues ENTER/EXIT. All outputs are registered.
- BCD increment: ones 9 -> 0 with tens+1; otherwise ones+1.
- BCD decrement: ones 0 -> 9 with tens-1; otherwise ones-1.
- Digits never leave 0..9.
- Saturation:
  - ENTER while Full: count unchanged, Rejected=1 for one cycle.
  - EXIT while Empty: count unchanged, Rejected=1 for one cycle.
- Clear: count -> 0 on the next edge. Clear beats a same-cycle ENTER/EXIT (event discarded, no Rejected). Clear does not reset the FSM.
- Full and Empty are derived from the registered count and update in the same cycle as the digits.
- End-to-end latency is 2 sync + DEBOUNCE_CYCLES + 1 FSM + 1 counter cycles after the final beam clears.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, E1, E2, E3, X1, X2, X3).
  - BCD digit width constant (4).
  - BCD_NINE constant.
  - Helper constants for MAX_PERSONS split into tens and ones digits, so comparisons are done digit-wise.
- Sub-module beam_debouncer holds the synchroniser and debounce counter, parameterised by DEBOUNCE_CYCLES. It is instantiated twice.
- FSM, timeout and BCD counter stay in the top-level module.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, MAX_PERSONS=44, each beam level held 10 cycles):
- Reset, then apply O, O+I, I, none -> count 00 to 01; Rejected stays 0; Empty falls.
- From 01, apply I, O+I, O, none -> count 01 to 00; Empty=1. Repeat the exit -> count stays 00, one Rejected pulse.
- Preload 09 via nine entries, then one entry -> 10. Then one exit -> 09 (checks the ones carry and borrow).
- Drive the count to 44, then attempt an entry -> stays 44, Full=1, one Rejected pulse.
- Glitches on OuterBeam of 1-3 cycles -> no FSM movement. Apply O then hold O+I for 150 cycles -> timeout to IDLE, count unchanged.
- Abort and priority cases:
  - O then none (back-out) -> no change.
  - Assert Clear in the same cycle the FSM issues ENTER at count 05 -> 00, no Rejected.
  - Assert Reset mid-E2 -> all outputs return to reset values.
